store_drain_ctrl: RTL and testbench

Commit-side drain controller for the store unit. It buffers committed stores in a small in-order queue and sequences them, together with AMO requests, onto the single data-cache write port using a req/gnt handshake. It enforces program order between stores and AMOs and reports drain completion for fences. It sits between the store unit's commit path and the dcache store port.

---
 rtl/store_drain_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_store_drain_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_ctrl.sv
// ============================================================================
// Module      : store_drain_ctrl
// Description : Drains committed stores and AMOs, in program order, onto the
//               single dcache write port using a req/gnt handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_drain_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 56,
  parameter int DATA_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [ADDR_W-1:0]          st_addr_i,
  input  logic [DATA_W-1:0]          st_data_i,
  input  logic [DATA_W/8-1:0]        st_be_i,
  input  logic                       amo_valid_i,
  output logic                       amo_ready_o,
  input  logic [ADDR_W-1:0]          amo_addr_i,
  input  logic [DATA_W-1:0]          amo_data_i,
  input  logic [3:0]                 amo_op_i,
  output logic                       amo_resp_valid_o,
  output logic [DATA_W-1:0]          amo_result_o,
  output logic                       dc_req_o,
  input  logic                       dc_gnt_i,
  output logic [ADDR_W-1:0]          dc_addr_o,
  output logic [DATA_W-1:0]          dc_data_o,
  output logic [DATA_W/8-1:0]        dc_be_o,
  output logic [3:0]                 dc_amo_op_o,
  input  logic                       dc_rvalid_i,
  input  logic [DATA_W-1:0]          dc_rdata_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_be_w  = DATA_W / 8;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STORE    = 2'd1,
    S_AMO      = 2'd2,
    S_AMO_WAIT = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [ADDR_W-1:0]   r_amo_addr;
  logic [DATA_W-1:0]   r_amo_data;
  logic [3:0]          r_amo_op;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_result;

  logic [ADDR_W-1:0]   r_q_addr [DEPTH];
  logic [DATA_W-1:0]   r_q_data [DEPTH];
  logic [c_be_w-1:0]   r_q_be   [DEPTH];

  logic                w_full;
  logic                w_idle_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_amo_acc;
  logic [c_cnt_w-1:0]  w_count_nxt;

  assign w_full       = (r_count == c_full);
  assign w_idle_empty = (r_state == S_IDLE) && (r_count == '0);

  // Reset forces every handshake output low, independent of stale state.
  assign st_ready_o       = rst_ni && !w_full && !fence_i;
  assign amo_ready_o      = rst_ni && w_idle_empty && amo_valid_i && !fence_i;
  assign dc_req_o         = rst_ni && ((r_state == S_STORE) || (r_state == S_AMO));
  assign amo_resp_valid_o = rst_ni && r_resp_valid;
  assign fence_done_o     = rst_ni && fence_i && w_idle_empty;
  assign empty_o          = w_idle_empty;
  assign count_o          = r_count;
  assign amo_result_o     = r_result;

  assign w_push    = st_valid_i && st_ready_o;
  assign w_pop     = (r_state == S_STORE) && dc_gnt_i;
  assign w_amo_acc = amo_ready_o;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    dc_addr_o   = r_q_addr[r_rptr];
    dc_data_o   = r_q_data[r_rptr];
    dc_be_o     = r_q_be[r_rptr];
    dc_amo_op_o = 4'd0;
    if (r_state == S_AMO) begin
      dc_addr_o   = r_amo_addr;
      dc_data_o   = r_amo_data;
      dc_be_o     = {c_be_w{1'b1}};
      dc_amo_op_o = r_amo_op;
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= st_addr_i;
      r_q_data[r_wptr] <= st_data_i;
      r_q_be[r_wptr]   <= st_be_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_amo_addr   <= '0;
      r_amo_data   <= '0;
      r_amo_op     <= '0;
      r_resp_valid <= 1'b0;
      r_result     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_count      <= w_count_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state <= S_STORE;
          end else if (w_amo_acc) begin
            r_amo_addr <= amo_addr_i;
            r_amo_data <= amo_data_i;
            r_amo_op   <= amo_op_i;
            r_state    <= S_AMO;
          end else if (w_push) begin
            // Go straight to STORE so the request appears the cycle after the push.
            r_state <= S_STORE;
          end
        end
        S_STORE: begin
          if (dc_gnt_i && (w_count_nxt == '0)) begin
            r_state <= S_IDLE;
          end
        end
        S_AMO: begin
          if (dc_gnt_i) begin
            r_state <= S_AMO_WAIT;
          end
        end
        S_AMO_WAIT: begin
          if (dc_rvalid_i) begin
            r_resp_valid <= 1'b1;
            r_result     <= dc_rdata_i;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_drain_ctrl.sv
// ============================================================================
// Module      : tb_store_drain_ctrl
// Description : Directed vector table plus hand-written AMO/stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_drain_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [55:0] st_addr_i;
  logic [63:0] st_data_i;
  logic [7:0]  st_be_i;
  logic        amo_valid_i;
  logic        amo_ready_o;
  logic [55:0] amo_addr_i;
  logic [63:0] amo_data_i;
  logic [3:0]  amo_op_i;
  logic        amo_resp_valid_o;
  logic [63:0] amo_result_o;
  logic        dc_req_o;
  logic        dc_gnt_i;
  logic [55:0] dc_addr_o;
  logic [63:0] dc_data_o;
  logic [7:0]  dc_be_o;
  logic [3:0]  dc_amo_op_o;
  logic        dc_rvalid_i;
  logic [63:0] dc_rdata_i;
  logic        fence_i;
  logic        fence_done_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  store_drain_ctrl #(.DEPTH(4), .ADDR_W(56), .DATA_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i),
    .amo_valid_i(amo_valid_i), .amo_ready_o(amo_ready_o), .amo_addr_i(amo_addr_i),
    .amo_data_i(amo_data_i), .amo_op_i(amo_op_i),
    .amo_resp_valid_o(amo_resp_valid_o), .amo_result_o(amo_result_o),
    .dc_req_o(dc_req_o), .dc_gnt_i(dc_gnt_i), .dc_addr_o(dc_addr_o),
    .dc_data_o(dc_data_o), .dc_be_o(dc_be_o), .dc_amo_op_o(dc_amo_op_o),
    .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  typedef struct {
    logic        rst_n;
    logic        st_valid;
    logic [15:0] addr;
    logic        gnt;
    logic        fence;
    logic        exp_ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic [2:0]  exp_count;
    logic        exp_empty;
    logic        exp_fdone;
    logic        chk_state;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic vec_t mk(logic rst_n, logic v, logic [15:0] a, logic g, logic f,
                              logic er, logic eq, logic [15:0] ea, logic [2:0] ec,
                              logic ee, logic efd, logic cs);
    vec_t t;
    t.rst_n = rst_n; t.st_valid = v; t.addr = a; t.gnt = g; t.fence = f;
    t.exp_ready = er; t.exp_req = eq; t.exp_addr = ea; t.exp_count = ec;
    t.exp_empty = ee; t.exp_fdone = efd; t.chk_state = cs;
    return t;
  endfunction

  initial begin
    rst_ni = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
    amo_valid_i = 1'b0; amo_addr_i = '0; amo_data_i = '0; amo_op_i = '0;
    dc_gnt_i = 1'b0; dc_rvalid_i = 1'b0; dc_rdata_i = '0; fence_i = 1'b0;

    //            rst v  addr     g  f  rdy req eaddr    cnt emp fd chk
    // reset held with a store offered
    vecs.push_back(mk(0, 1, 16'h100, 0, 0, 0, 0, 16'h000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h100, 0, 0, 0, 0, 16'h000, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 16'h100, 0, 0, 0, 0, 16'h000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    // fill to full with grant low, fifth store refused
    vecs.push_back(mk(1, 1, 16'h100, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 16'h108, 0, 0, 1, 1, 16'h100, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h110, 0, 0, 1, 1, 16'h100, 2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h118, 0, 0, 1, 1, 16'h100, 3, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h120, 0, 0, 0, 1, 16'h100, 4, 0, 0, 1));
    // drain one per cycle in order
    vecs.push_back(mk(1, 0, 16'h000, 1, 0, 0, 1, 16'h100, 4, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 0, 1, 1, 16'h108, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 0, 1, 1, 16'h110, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 0, 1, 1, 16'h118, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    // fence with 3 queued; store offered under fence is refused
    vecs.push_back(mk(1, 1, 16'h200, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 16'h208, 0, 0, 1, 1, 16'h200, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h210, 0, 0, 1, 1, 16'h200, 2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h218, 0, 1, 0, 1, 16'h200, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 1, 0, 1, 16'h200, 3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 1, 0, 1, 16'h208, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 1, 0, 1, 16'h210, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 0, 1, 0, 0, 16'h000, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 16'h000, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    // simultaneous push and pop keeps the count
    vecs.push_back(mk(1, 1, 16'h300, 1, 0, 1, 0, 16'h000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 16'h308, 1, 0, 1, 1, 16'h300, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 1, 0, 1, 1, 16'h308, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h000, 0, 0, 1, 0, 16'h000, 0, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_ni     = vecs[i].rst_n;
      st_valid_i = vecs[i].st_valid;
      st_addr_i  = 56'(vecs[i].addr);
      st_data_i  = 64'hD47A_0000_0000_0000 | 64'(vecs[i].addr);
      st_be_i    = 8'hFF;
      dc_gnt_i   = vecs[i].gnt;
      fence_i    = vecs[i].fence;
      #1;
      chk($sformatf("vec%0d ready/req/fdone", i),
          128'({st_ready_o, dc_req_o, fence_done_o, amo_ready_o}),
          128'({vecs[i].exp_ready, vecs[i].exp_req, vecs[i].exp_fdone, 1'b0}));
      if (vecs[i].exp_req)
        chk($sformatf("vec%0d dc_addr", i), 128'({dc_addr_o, dc_amo_op_o}),
            128'({56'(vecs[i].exp_addr), 4'd0}));
      if (vecs[i].chk_state)
        chk($sformatf("vec%0d count/empty", i), 128'({count_o, empty_o}),
            128'({vecs[i].exp_count, vecs[i].exp_empty}));
      step();
    end
    st_valid_i = 1'b0; dc_gnt_i = 1'b0; fence_i = 1'b0;

    // Grant stall: request fields hold for 5 cycles, single pop on grant
    st_valid_i = 1'b1; st_addr_i = 56'h400; st_data_i = 64'h0123_4567_89AB_CDEF; st_be_i = 8'h3C;
    step();
    st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d", k), {dc_req_o, dc_addr_o, dc_data_o, dc_be_o, dc_amo_op_o, count_o},
          {1'b1, 56'h400, 64'h0123_4567_89AB_CDEF, 8'h3C, 4'd0, 3'd1});
      step();
    end
    dc_gnt_i = 1'b1;
    step();
    dc_gnt_i = 1'b0;
    #1;
    chk("stall after grant", 128'({dc_req_o, count_o, empty_o}), 128'({1'b0, 3'd0, 1'b1}));
    step();

    // AMO ordering behind two queued stores
    st_valid_i = 1'b1; st_addr_i = 56'h500;
    step();
    st_addr_i = 56'h508; amo_valid_i = 1'b1; amo_addr_i = 56'h200; amo_op_i = 4'h3;
    amo_data_i = 64'h55;
    #1; chk("amo blocked c1", 128'(amo_ready_o), 128'(1'b0));
    step();
    st_valid_i = 1'b0; dc_gnt_i = 1'b1;
    #1; chk("amo blocked c2", 128'({amo_ready_o, dc_req_o, dc_addr_o}), 128'({1'b0, 1'b1, 56'h500}));
    step();
    #1; chk("amo blocked c3", 128'({amo_ready_o, dc_req_o, dc_addr_o}), 128'({1'b0, 1'b1, 56'h508}));
    step();
    dc_gnt_i = 1'b0;
    #1; chk("amo accept", 128'({amo_ready_o, dc_req_o}), 128'({1'b1, 1'b0}));
    step();
    amo_valid_i = 1'b0; dc_gnt_i = 1'b1;
    #1; chk("amo issue", {dc_req_o, dc_addr_o, dc_data_o, dc_be_o, dc_amo_op_o},
            {1'b1, 56'h200, 64'h55, 8'hFF, 4'h3});
    step();
    dc_gnt_i = 1'b0;
    #1; chk("amo wait", 128'({dc_req_o, amo_resp_valid_o}), 128'({1'b0, 1'b0}));
    step();
    dc_rvalid_i = 1'b1; dc_rdata_i = 64'hDEAD;
    #1; chk("amo rvalid cycle", 128'(amo_resp_valid_o), 128'(1'b0));
    step();
    dc_rvalid_i = 1'b0; dc_rdata_i = '0;
    #1; chk("amo resp", 128'({amo_resp_valid_o, amo_result_o}), 128'({1'b1, 64'hDEAD}));
    step();
    #1; chk("amo resp single", 128'({amo_resp_valid_o, empty_o}), 128'({1'b0, 1'b1}));

    // Store arriving in AMO_WAIT is held until the AMO returns
    amo_valid_i = 1'b1; amo_addr_i = 56'h280; amo_op_i = 4'h5; amo_data_i = 64'h77;
    #1; chk("amo2 accept", 128'(amo_ready_o), 128'(1'b1));
    step();
    amo_valid_i = 1'b0; dc_gnt_i = 1'b1;
    #1; chk("amo2 issue", 128'({dc_req_o, dc_amo_op_o}), 128'({1'b1, 4'h5}));
    step();
    dc_gnt_i = 1'b0; st_valid_i = 1'b1; st_addr_i = 56'h600; st_data_i = 64'h66; st_be_i = 8'h0F;
    #1; chk("push in wait", 128'({st_ready_o, dc_req_o}), 128'({1'b1, 1'b0}));
    step();
    st_valid_i = 1'b0; dc_rvalid_i = 1'b1; dc_rdata_i = 64'hBEEF;
    #1; chk("held store", 128'({count_o, dc_req_o, empty_o}), 128'({3'd1, 1'b0, 1'b0}));
    step();
    dc_rvalid_i = 1'b0;
    #1; chk("amo2 resp", 128'({amo_resp_valid_o, amo_result_o, dc_req_o, count_o}),
            128'({1'b1, 64'hBEEF, 1'b0, 3'd1}));
    step();
    dc_gnt_i = 1'b1;
    #1; chk("held store issues", {dc_req_o, dc_addr_o, dc_data_o, dc_be_o, dc_amo_op_o},
            {1'b1, 56'h600, 64'h66, 8'h0F, 4'd0});
    step();
    dc_gnt_i = 1'b0; dc_rvalid_i = 1'b1; dc_rdata_i = 64'h1234;
    #1; chk("drained", 128'({count_o, empty_o}), 128'({3'd0, 1'b1}));
    step();
    dc_rvalid_i = 1'b0;
    #1; chk("rvalid ignored idle", 128'(amo_resp_valid_o), 128'(1'b0));

    // Reset during AMO_WAIT discards the AMO; a late rvalid is ignored
    amo_valid_i = 1'b1; amo_addr_i = 56'h2C0; amo_op_i = 4'h2;
    step();
    amo_valid_i = 1'b0; dc_gnt_i = 1'b1;
    step();
    dc_gnt_i = 1'b0; rst_ni = 1'b0;
    step();
    rst_ni = 1'b1; dc_rvalid_i = 1'b1; dc_rdata_i = 64'h9999;
    step();
    dc_rvalid_i = 1'b0;
    #1; chk("reset drops amo", 128'({amo_resp_valid_o, dc_req_o, empty_o, count_o}),
            128'({1'b0, 1'b0, 1'b1, 3'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
